// File: rtl/decode_cycle_pkg.sv
// Shared decode-stage types: opcodes, ALU/immediate encodings and the D/E payload.
package decode_cycle_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREG   = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Encodings shared with the execute-stage ALU.
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10
  } imm_src_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  typedef struct packed {
    logic     reg_write;
    logic     result_src;
    logic     mem_write;
    logic     branch;
    logic     alu_src;
    imm_src_e imm_src;
    alu_op_e  alu_op;
  } ctrl_t;

  typedef struct packed {
    logic              reg_write;
    logic              result_src;
    logic              mem_write;
    logic              branch;
    logic              alu_src;
    alu_ctrl_e         alu_control;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm_ext;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_plus4;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
  } de_t;

  function automatic logic [XLEN-1:0] imm_extend(input logic [31:0] instr, input imm_src_e src);
    logic s;
    s = instr[31];
    case (src)
      IMM_S:   imm_extend = {{20{s}}, instr[31:25], instr[11:7]};
      IMM_B:   imm_extend = {{19{s}}, s, instr[7], instr[30:25], instr[11:8], 1'b0};
      default: imm_extend = {{20{s}}, instr[31:20]};
    endcase
  endfunction

endpackage

// File: rtl/decode_cycle_reg_file.sv
// 2-read/1-write architectural register file with x0 hardwired to zero and write-first bypass.
module decode_cycle_reg_file
  import decode_cycle_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [XLEN-1:0]   wd,
  output logic [XLEN-1:0]   rd1_c,
  output logic [XLEN-1:0]   rd2_c
);

  logic [XLEN-1:0] mem_q [NREG];
  logic [XLEN-1:0] mem_d [NREG];
  logic            wr_en;

  assign wr_en = we && (wa != '0);

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wa] = wd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Same-cycle writeback is forwarded so decode never sees a stale operand.
  always_comb begin
    rd1_c = '0;
    rd2_c = '0;
    if (ra1 != '0) rd1_c = (wr_en && wa == ra1) ? wd : mem_q[ra1];
    if (ra2 != '0) rd2_c = (wr_en && wa == ra2) ? wd : mem_q[ra2];
  end

endmodule

// File: rtl/decode_cycle.sv
// RV32I-subset decode stage: control decode, immediate extension, register read and D/E register.
module decode_cycle
  import decode_cycle_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       InstrD,
  input  logic [XLEN-1:0]   PCD,
  input  logic [XLEN-1:0]   PCPlus4D,
  input  logic              FlushE,
  input  logic              RegWriteW,
  input  logic [REG_AW-1:0] RDW,
  input  logic [XLEN-1:0]   ResultW,
  output logic [REG_AW-1:0] RS1D,
  output logic [REG_AW-1:0] RS2D,
  output logic              RegWriteE,
  output logic              ResultSrcE,
  output logic              MemWriteE,
  output logic              BranchE,
  output logic              ALUSrcE,
  output logic [2:0]        ALUControlE,
  output logic [XLEN-1:0]   RD1E,
  output logic [XLEN-1:0]   RD2E,
  output logic [XLEN-1:0]   ImmExtE,
  output logic [XLEN-1:0]   PCE,
  output logic [XLEN-1:0]   PCPlus4E,
  output logic [REG_AW-1:0] RDE,
  output logic [REG_AW-1:0] RS1E,
  output logic [REG_AW-1:0] RS2E
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  ctrl_t           ctrl;
  alu_ctrl_e       alu_control;
  logic [XLEN-1:0] rd1, rd2;
  de_t             de_d, de_q;

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign RS1D   = InstrD[19:15];
  assign RS2D   = InstrD[24:20];

  // Main decoder; unknown opcodes fall through as a NOP.
  always_comb begin
    ctrl = ctrl_t'('0);
    case (opcode)
      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = 1'b1;
        ctrl.alu_src    = 1'b1;
      end
      OP_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.imm_src   = IMM_S;
      end
      OP_RTYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      OP_ITYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      OP_BRANCH: begin
        ctrl.branch  = 1'b1;
        ctrl.imm_src = IMM_B;
        ctrl.alu_op  = ALUOP_SUB;
      end
      default: ;
    endcase
  end

  // ALU decoder; InstrD[30] selects sub only for register-register ops.
  always_comb begin
    alu_control = ALU_ADD;
    case (ctrl.alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (opcode[5] && InstrD[30]) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

  decode_cycle_reg_file u_reg_file (
    .clk   (clk),
    .rst_n (rst),
    .ra1   (RS1D),
    .ra2   (RS2D),
    .we    (RegWriteW),
    .wa    (RDW),
    .wd    (ResultW),
    .rd1_c (rd1),
    .rd2_c (rd2)
  );

  always_comb begin
    de_d = de_t'('0);
    if (!FlushE) begin
      de_d.reg_write   = ctrl.reg_write;
      de_d.result_src  = ctrl.result_src;
      de_d.mem_write   = ctrl.mem_write;
      de_d.branch      = ctrl.branch;
      de_d.alu_src     = ctrl.alu_src;
      de_d.alu_control = alu_control;
      de_d.rd1         = rd1;
      de_d.rd2         = rd2;
      de_d.imm_ext     = imm_extend(InstrD, ctrl.imm_src);
      de_d.pc          = PCD;
      de_d.pc_plus4    = PCPlus4D;
      de_d.rd          = InstrD[11:7];
      de_d.rs1         = RS1D;
      de_d.rs2         = RS2D;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) de_q <= de_t'('0);
    else      de_q <= de_d;
  end

  assign RegWriteE   = de_q.reg_write;
  assign ResultSrcE  = de_q.result_src;
  assign MemWriteE   = de_q.mem_write;
  assign BranchE     = de_q.branch;
  assign ALUSrcE     = de_q.alu_src;
  assign ALUControlE = de_q.alu_control;
  assign RD1E        = de_q.rd1;
  assign RD2E        = de_q.rd2;
  assign ImmExtE     = de_q.imm_ext;
  assign PCE         = de_q.pc;
  assign PCPlus4E    = de_q.pc_plus4;
  assign RDE         = de_q.rd;
  assign RS1E        = de_q.rs1;
  assign RS2E        = de_q.rs2;

endmodule

// File: tb/tb_decode_cycle.sv
// Table-driven scoreboard bench for the decode stage and its D/E register.
module tb_decode_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
  logic        FlushE, RegWriteW;
  logic [4:0]  RDW, RS1D, RS2D, RDE, RS1E, RS2E;
  logic        RegWriteE, ResultSrcE, MemWriteE, BranchE, ALUSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;

  decode_cycle dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .FlushE(FlushE), .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
    .RS1D(RS1D), .RS2D(RS2D), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
    .MemWriteE(MemWriteE), .BranchE(BranchE), .ALUSrcE(ALUSrcE),
    .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .RDE(RDE), .RS1E(RS1E), .RS2E(RS2E)
  );

  always #5 clk = ~clk;

  // ctrl = {RegWrite, ResultSrc, MemWrite, Branch, ALUSrc, ALUControl[2:0]}
  typedef struct {
    logic [31:0] instr;
    logic        flush;
    logic        rw;
    logic [4:0]  rdw;
    logic [31:0] res;
    logic [7:0]  ctrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [14:0] regs;
  } vec_t;

  typedef struct {
    int          idx;
    logic [7:0]  ctrl;
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [14:0] regs;
  } exp_t;

  localparam int NV = 14;
  vec_t vecs [NV];
  exp_t sb [$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(logic [31:0] instr, logic flush, logic rw, logic [4:0] rdw,
                              logic [31:0] res, logic [7:0] ctrl, logic [31:0] rd1,
                              logic [31:0] rd2, logic [31:0] imm, logic [4:0] rd,
                              logic [4:0] rs1, logic [4:0] rs2);
    vec_t v;
    v.instr = instr; v.flush = flush; v.rw = rw; v.rdw = rdw; v.res = res;
    v.ctrl = ctrl; v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.regs = {rd, rs1, rs2};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_e(input exp_t e);
    string t;
    t = $sformatf("v%0d", e.idx);
    check({t, " ctrl"}, 32'({RegWriteE, ResultSrcE, MemWriteE, BranchE, ALUSrcE, ALUControlE}), 32'(e.ctrl));
    check({t, " RD1E"}, RD1E, e.rd1);
    check({t, " RD2E"}, RD2E, e.rd2);
    check({t, " ImmExtE"}, ImmExtE, e.imm);
    check({t, " PCE"}, PCE, e.pc);
    check({t, " PCPlus4E"}, PCPlus4E, e.pc4);
    check({t, " regs"}, 32'({RDE, RS1E, RS2E}), 32'(e.regs));
  endtask

  task automatic check_all_zero(input string name);
    check({name, " ctrl"}, 32'({RegWriteE, ResultSrcE, MemWriteE, BranchE, ALUSrcE, ALUControlE}), 32'h0);
    check({name, " data"}, RD1E | RD2E | ImmExtE | PCE | PCPlus4E, 32'h0);
    check({name, " regs"}, 32'({RDE, RS1E, RS2E}), 32'h0);
  endtask

  initial begin
    exp_t e;
    //          instr         fl rw rdw res           ctrl       rd1           rd2           imm           rd  rs1 rs2
    vecs[0]  = mk(32'h00A08113, 0, 0, 0, 32'h0,        8'b1000_1000, 32'h0,        32'h0,        32'd10,       2,  1,  10); // x1 still 0 after reset
    vecs[1]  = mk(32'h00000013, 0, 1, 1, 32'd5,        8'b1000_1000, 32'h0,        32'h0,        32'h0,        0,  0,  0);  // write x1=5
    vecs[2]  = mk(32'h00A08113, 0, 0, 0, 32'h0,        8'b1000_1000, 32'd5,        32'h0,        32'd10,       2,  1,  10); // addi x2,x1,10
    vecs[3]  = mk(32'h403181B3, 0, 1, 3, 32'h1234,     8'b1000_0001, 32'h1234,     32'h1234,     32'h403,      3,  3,  3);  // bypass sub
    vecs[4]  = mk(32'h00000233, 0, 1, 0, 32'hFFFFFFFF, 8'b1000_0000, 32'h0,        32'h0,        32'h0,        4,  0,  0);  // x0 write ignored
    vecs[5]  = mk(32'hFE20AE23, 0, 0, 0, 32'h0,        8'b0010_1000, 32'd5,        32'h0,        32'hFFFFFFFC, 28, 1,  2);  // sw
    vecs[6]  = mk(32'hFE000CE3, 0, 0, 0, 32'h0,        8'b0001_0001, 32'h0,        32'h0,        32'hFFFFFFF8, 25, 0,  0);  // beq
    vecs[7]  = mk(32'h0080A283, 1, 1, 6, 32'h77,       8'h00,        32'h0,        32'h0,        32'h0,        0,  0,  0);  // flushed lw, x6 written
    vecs[8]  = mk(32'h001303B3, 0, 0, 0, 32'h0,        8'b1000_0000, 32'h77,       32'd5,        32'h1,        7,  6,  1);  // add x7,x6,x1
    vecs[9]  = mk(32'h0000007F, 0, 0, 0, 32'h0,        8'h00,        32'h0,        32'h0,        32'h0,        0,  0,  0);  // unknown opcode
    vecs[10] = mk(32'h0080A283, 0, 0, 0, 32'h0,        8'b1100_1000, 32'd5,        32'h0,        32'd8,        5,  1,  8);  // lw
    vecs[11] = mk(32'h0060E433, 0, 0, 0, 32'h0,        8'b1000_0011, 32'd5,        32'h77,       32'h6,        8,  1,  6);  // or
    vecs[12] = mk(32'hFFF0A493, 0, 0, 0, 32'h0,        8'b1000_1101, 32'd5,        32'h0,        32'hFFFFFFFF, 9,  1,  31); // slti
    vecs[13] = mk(32'h40008513, 0, 0, 0, 32'h0,        8'b1000_1000, 32'd5,        32'h0,        32'h400,      10, 1,  0);  // addi, bit30 set

    // Reset held with a live instruction and a pending write.
    rst = 1'b0; InstrD = 32'h00500093; PCD = 32'h40; PCPlus4D = 32'h44;
    FlushE = 1'b0; RegWriteW = 1'b1; RDW = 5'd1; ResultW = 32'd5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    check("RS1D comb", 32'(RS1D), 32'd0);
    check("RS2D comb", 32'(RS2D), 32'd5);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      if (i != 0) @(negedge clk);
      if (sb.size() != 0) check_e(sb.pop_front());
      InstrD = vecs[i].instr; FlushE = vecs[i].flush; RegWriteW = vecs[i].rw;
      RDW = vecs[i].rdw; ResultW = vecs[i].res;
      PCD = 32'h100 + 32'(4 * i); PCPlus4D = PCD + 32'd4;
      e.idx = i; e.ctrl = vecs[i].ctrl; e.rd1 = vecs[i].rd1; e.rd2 = vecs[i].rd2;
      e.imm = vecs[i].imm; e.regs = vecs[i].regs;
      e.pc  = vecs[i].flush ? 32'h0 : PCD;
      e.pc4 = vecs[i].flush ? 32'h0 : PCPlus4D;
      sb.push_back(e);
    end
    @(negedge clk);
    if (sb.size() != 0) check_e(sb.pop_front());
    check("scoreboard drained", 32'(sb.size()), 32'd0);

    // Mid-cycle asynchronous reset clears outputs and register file at once.
    RegWriteW = 1'b0; InstrD = 32'h00A08113; PCD = 32'h200; PCPlus4D = 32'h204;
    @(posedge clk);
    #3 rst = 1'b0;
    #1 check_all_zero("async reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post-reset x1 read", RD1E, 32'h0);
    check("post-reset ImmExtE", ImmExtE, 32'd10);
    check("post-reset PCE", PCE, 32'h200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_cycle.md
Name: decode_cycle

Overview:
Instruction-decode stage of the 5-stage RV32I-subset pipeline, directly upstream of execute_cycle.
- Decodes InstrD into control signals and sign-extends the immediate.
- Reads two operands from an internal 32x32 register file, which the writeback stage writes.
- Registers everything into the D/E pipeline register feeding the execute stage, with a synchronous flush from the hazard unit.

Parameters:
XLEN, 32, datapath width in bits.
NREG, 32, number of architectural registers; x0 is hardwired to zero.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-low
InstrD  input  32  instruction from the fetch/decode pipeline register
PCD  input  32  PC of InstrD
PCPlus4D  input  32  PCD+4
FlushE  input  1  hazard unit: load a bubble into the D/E register
RegWriteW  input  1  writeback write enable
RDW  input  5  writeback destination register
ResultW  input  32  writeback data
RS1D  output  5  InstrD[19:15], combinational, for load-use detection
RS2D  output  5  InstrD[24:20], combinational
RegWriteE, ResultSrcE, MemWriteE, BranchE, ALUSrcE  output  1 each  registered controls
ALUControlE  output  3  registered ALU operation
RD1E, RD2E, ImmExtE, PCE, PCPlus4E  output  32 each  registered data
RDE, RS1E, RS2E  output  5 each  registered register indices

Behaviour:
Reset (rst low, asynchronous):
- All E outputs are 0.
- All register-file entries are 0.
- Release is synchronous to the next rising edge.

Main decoder, by opcode InstrD[6:0]. Columns: RegWrite, ResultSrc, MemWrite, Branch, ALUSrc, ImmSrc, ALUOp.
- lw 0000011: 1,1,0,0,1,I,00
- sw 0100011: 0,x→0,1,0,1,S,00
- R-type 0110011: 1,0,0,0,0,x→I,10
- I-ALU 0010011: 1,0,0,0,1,I,10
- beq 1100011: 0,0,0,1,0,B,01
- Any other opcode: all controls 0, so the instruction behaves as a NOP.

ALU decoder:
- ALUOp 00 gives 000 (add).
- ALUOp 01 gives 001 (sub).
- ALUOp 10, by funct3:
  - 000: sub (001) if opcode[5] & InstrD[30], else add (000).
  - 010: slt (101).
  - 110: or (011).
  - 111: and (010).
  - Any other funct3: add.

Immediate extension, with s = InstrD[31]:
- I: {20{s}, InstrD[31:20]}
- S: {20{s}, InstrD[31:25], InstrD[11:7]}
- B: {19{s}, s, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0}

Register file:
- Two combinational read ports, addressed by RS1D and RS2D.
- One write port, written on the rising edge when RegWriteW=1 and RDW≠0.
- Writes to x0 are ignored; reads of x0 return 0.
- Write-first bypass: if RegWriteW and RDW≠0 and RDW equals a read address, that read port returns ResultW in the same cycle.

D/E pipeline register:
- Latency is 1 cycle from D inputs to E outputs.
- RDE captures InstrD[11:7]; PCE captures PCD; PCPlus4E captures PCPlus4D.
- FlushE=1 at a rising edge loads all-zero on that edge, i.e. a NOP bubble with RegWriteE=MemWriteE=BranchE=0.
- When FlushE and a register-file write occur on the same edge, both take effect: the flush does not block RegWriteW.
- There is no stall input. Holding decode is the fetch-stage register's job; execute always advances.

Reset mid-operation zeros both the pipeline register and the register file immediately.

Decomposition:
- Shared package holds:
  - opcode constants: OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH
  - ALUControl encodings: ALU_ADD=000, ALU_SUB=001, ALU_AND=010, ALU_OR=011, ALU_SLT=101; these are shared with the ALU
  - ImmSrc encodings: IMM_I=00, IMM_S=01, IMM_B=10
  - ALUOp encodings
- One sub-module is natural: reg_file, containing the 2R/1W register array, the x0 rule and the write-first bypass.
- Decoder and immediate logic stay inline.

Test Plan:
- Reset: hold rst low with InstrD=0x00500093 → all E outputs 0; after release, a read of x1 returns 0.
- Writeback then I-ALU: write x1=5 (RegWriteW=1, RDW=1, ResultW=5); next edge InstrD=0x00A08113 (addi x2,x1,10) → RD1E=5, ImmExtE=10, ALUSrcE=1, RegWriteE=1, ALUControlE=000, RDE=2.
- Write-first bypass: on the same cycle, RegWriteW writes x3=0x1234 while InstrD=0x403181B3 (sub x3,x3,x3) → RD1E=RD2E=0x1234, ALUControlE=001.
- x0 protection: write RDW=0, ResultW=0xFFFFFFFF, then read x0 → RD1E=0.
- Store and branch immediates: sw x2,-4(x1) (0xFE20AE23) → ImmExtE=0xFFFFFFFC, MemWriteE=1, RegWriteE=0. beq x0,x0,-8 (0xFE000CE3) → BranchE=1, ImmExtE=0xFFFFFFF8, ALUControlE=001.
- Flush and unknown opcode: FlushE=1 with a valid lw → all E controls 0 next cycle. InstrD=0x0000007F → all controls 0.
